// File: rtl/mac_lookup_arbiter.sv
// Round-robin arbiter and watchdog in front of the MAC hash table's search/learn port, plus aging tick generation.
// Optional statistics counters are built when MAC_ARB_STATS_EN is defined.
module mac_lookup_arbiter #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter logic [31:0] AGING_PERIOD = 32'd1000000,
    parameter logic [15:0] TIMEOUT      = 16'd2047
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      port_req,
    input  logic [NUM_PORTS-1:0]      port_source,
    input  logic [48*NUM_PORTS-1:0]   port_mac,
    input  logic [16*NUM_PORTS-1:0]   port_portmap,
    input  logic [10*NUM_PORTS-1:0]   port_hash,
    output logic [NUM_PORTS-1:0]      port_ack,
    output logic [NUM_PORTS-1:0]      port_nak,
    output logic [15:0]               port_result,
    output logic                      se_source,
    output logic [47:0]               se_mac,
    output logic [15:0]               se_portmap,
    output logic [9:0]                se_hash,
    output logic                      se_req,
    input  logic                      se_ack,
    input  logic                      se_nak,
    input  logic [15:0]               se_result,
    output logic                      aging_req,
    input  logic                      aging_ack,
    output logic                      timeout_err,
    output logic                      aging_overrun,
    output logic [31:0]               stat_ack_cnt,
    output logic [31:0]               stat_nak_cnt,
    output logic [31:0]               stat_to_cnt
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] cand;
    logic             pick_valid;
    logic [15:0]      wd_cnt;
    logic [31:0]      aging_cnt;

    // First requester strictly after the round-robin pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % NUM_PORTS);
            if (!pick_valid && port_req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Transaction FSM: grant, supervise the table, return one response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= PTR_W'(NUM_PORTS - 1);
            gnt         <= '0;
            wd_cnt      <= '0;
            se_req      <= 1'b0;
            se_source   <= 1'b0;
            se_mac      <= '0;
            se_portmap  <= '0;
            se_hash     <= '0;
            port_ack    <= '0;
            port_nak    <= '0;
            port_result <= '0;
            timeout_err <= 1'b0;
        end else begin
            port_ack    <= '0;
            port_nak    <= '0;
            port_result <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt        <= pick;
                        se_source  <= port_source[pick];
                        se_mac     <= port_mac[32'(pick)*48 +: 48];
                        se_portmap <= port_portmap[32'(pick)*16 +: 16];
                        se_hash    <= port_hash[32'(pick)*10 +: 10];
                        se_req     <= 1'b1;
                        wd_cnt     <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (se_nak) begin
                        port_nak[gnt] <= 1'b1;
                        se_req        <= 1'b0;
                        rr_ptr        <= gnt;
                        state         <= RESP;
                    end else if (se_ack) begin
                        port_ack[gnt] <= 1'b1;
                        port_result   <= se_source ? 16'd0 : se_result;
                        se_req        <= 1'b0;
                        rr_ptr        <= gnt;
                        state         <= RESP;
                    end else if (wd_cnt == TIMEOUT) begin
                        port_nak[gnt] <= 1'b1;
                        timeout_err   <= 1'b1;
                        se_req        <= 1'b0;
                        rr_ptr        <= gnt;
                        state         <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Aging tick: a wrap while a sweep is still outstanding is flagged, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            aging_cnt     <= '0;
            aging_req     <= 1'b0;
            aging_overrun <= 1'b0;
        end else if (aging_cnt == AGING_PERIOD - 32'd1) begin
            aging_cnt <= '0;
            if (aging_req && !aging_ack) begin
                aging_overrun <= 1'b1;
            end else begin
                aging_req <= 1'b1;
            end
        end else begin
            aging_cnt <= aging_cnt + 32'd1;
            if (aging_ack) begin
                aging_req <= 1'b0;
            end
        end
    end

`ifdef MAC_ARB_STATS_EN
    logic [31:0] ack_cnt;
    logic [31:0] nak_cnt;
    logic [31:0] to_cnt;
    logic        to_evt;

    assign to_evt = (state == BUSY) && !se_ack && !se_nak && (wd_cnt == TIMEOUT);

    // Saturating event counters; ack/nak follow the registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= '0;
            nak_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if ((|port_ack) && (ack_cnt != 32'hFFFF_FFFF)) ack_cnt <= ack_cnt + 32'd1;
            if ((|port_nak) && (nak_cnt != 32'hFFFF_FFFF)) nak_cnt <= nak_cnt + 32'd1;
            if (to_evt && (to_cnt != 32'hFFFF_FFFF))       to_cnt  <= to_cnt + 32'd1;
        end
    end

    assign stat_ack_cnt = ack_cnt;
    assign stat_nak_cnt = nak_cnt;
    assign stat_to_cnt  = to_cnt;
`else
    assign stat_ack_cnt = 32'd0;
    assign stat_nak_cnt = 32'd0;
    assign stat_to_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Self-checking bench for mac_lookup_arbiter: directed scenarios plus randomized traffic against a scoreboard model.
module tb_mac_lookup_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned PW = 2;
    localparam logic [15:0] TO = 16'd2047;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     port_req, port_source, port_ack, port_nak;
    logic [48*NP-1:0]  port_mac;
    logic [16*NP-1:0]  port_portmap;
    logic [10*NP-1:0]  port_hash;
    logic [15:0]       port_result, se_portmap, se_result;
    logic              se_source, se_req, se_ack, se_nak;
    logic [47:0]       se_mac;
    logic [9:0]        se_hash;
    logic              aging_req, aging_ack, timeout_err, aging_overrun;
    logic [31:0]       stat_ack_cnt, stat_nak_cnt, stat_to_cnt;

    always #5 clk = ~clk;

    mac_lookup_arbiter #(
        .NUM_PORTS    (NP),
        .AGING_PERIOD (32'd100),
        .TIMEOUT      (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .port_req      (port_req),
        .port_source   (port_source),
        .port_mac      (port_mac),
        .port_portmap  (port_portmap),
        .port_hash     (port_hash),
        .port_ack      (port_ack),
        .port_nak      (port_nak),
        .port_result   (port_result),
        .se_source     (se_source),
        .se_mac        (se_mac),
        .se_portmap    (se_portmap),
        .se_hash       (se_hash),
        .se_req        (se_req),
        .se_ack        (se_ack),
        .se_nak        (se_nak),
        .se_result     (se_result),
        .aging_req     (aging_req),
        .aging_ack     (aging_ack),
        .timeout_err   (timeout_err),
        .aging_overrun (aging_overrun),
        .stat_ack_cnt  (stat_ack_cnt),
        .stat_nak_cnt  (stat_nak_cnt),
        .stat_to_cnt   (stat_to_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc;

    // Reference model state
    bit [NP-1:0] pending;
    int          last;
    logic [47:0] mac_tab [NP];
    logic [15:0] pm_tab  [NP];
    logic [9:0]  hash_tab[NP];
    bit          src_tab [NP];
    int          exp_ack, exp_nak, exp_to;
    bit          chk_aging;
    int          order[$];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_grant(input bit [NP-1:0] p, input int l);
        for (int i = 1; i <= int'(NP); i++) begin
            int k;
            k = (l + i) % int'(NP);
            if (p[PW'(k)]) return k;
        end
        return -1;
    endfunction

    task automatic raise(input int p, input bit src, input logic [47:0] mac,
                         input logic [15:0] pm, input logic [9:0] h);
        mac_tab[PW'(p)]  = mac;
        pm_tab[PW'(p)]   = pm;
        hash_tab[PW'(p)] = h;
        src_tab[PW'(p)]  = src;
        port_source[PW'(p)]  = src;
        port_mac[48*p +: 48] = mac;
        port_portmap[16*p +: 16] = pm;
        port_hash[10*p +: 10] = h;
        port_req[PW'(p)] = 1'b1;
        pending[PW'(p)]  = 1'b1;
    endtask

    task automatic check_reset_state();
        check("rst_ctl", 64'({se_req, aging_req, timeout_err, aging_overrun, port_ack, port_nak}), 64'(0));
        check("rst_se_mac", 64'(se_mac), 64'(0));
        check("rst_fields", 64'({port_result, se_portmap, se_hash, se_source}), 64'(0));
        check("rst_stats", 64'({stat_ack_cnt, stat_nak_cnt}) | 64'(stat_to_cnt), 64'(0));
    endtask

    // Acts as the hash table for one transaction; kind 0 = ack, 1 = nak, 2 = ack+nak together.
    task automatic do_txn(input int kind, input int dly, input logic [15:0] res, input bit drop);
        int g, n, k;
        logic [NP-1:0] oh;
        g = next_grant(pending, last);
        n = 0;
        while (!se_req && n < 10) begin
            tick();
            n++;
        end
        check("se_req_rise", 64'(se_req), 64'(1));
        k = -1;
        for (int i = NP - 1; i >= 0; i--)
            if (pending[PW'(i)] && se_mac === mac_tab[PW'(i)]) k = i;
        order.push_back(k);
        check("grant_port", 64'(k), 64'(g));
        if (g < 0) return;
        check("se_mac", 64'(se_mac), 64'(mac_tab[PW'(g)]));
        check("se_ctl", 64'({se_source, se_hash, se_portmap}),
              64'({src_tab[PW'(g)], hash_tab[PW'(g)], pm_tab[PW'(g)]}));
        pending[PW'(g)] = 1'b0;
        if (drop) port_req[PW'(g)] = 1'b0;
        for (int i = 0; i < dly; i++) begin
            tick();
            check("se_hold", 64'({se_req, se_mac}), 64'({1'b1, mac_tab[PW'(g)]}));
            if (chk_aging) check("aging_held", 64'(aging_req), 64'(1));
        end
        se_ack    = (kind != 1);
        se_nak    = (kind != 0);
        se_result = res;
        tick();
        se_ack = 1'b0;
        se_nak = 1'b0;
        oh = '0;
        oh[PW'(g)] = 1'b1;
        check("port_ack", 64'(port_ack), (kind == 0) ? 64'(oh) : 64'(0));
        check("port_nak", 64'(port_nak), (kind != 0) ? 64'(oh) : 64'(0));
        if (kind == 0)
            check("port_result", 64'(port_result), src_tab[PW'(g)] ? 64'(0) : 64'(res));
        check("se_req_drop", 64'(se_req), 64'(0));
        port_req[PW'(g)] = 1'b0;
        last = g;
        if (kind == 0) exp_ack++;
        else           exp_nak++;
        tick();
        check("resp_quiet", 64'({port_ack, port_nak}), 64'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        port_req = '0; port_source = '0; port_mac = '0; port_portmap = '0; port_hash = '0;
        se_ack = 1'b0; se_nak = 1'b0; se_result = '0; aging_ack = 1'b0;
        pending = '0; last = NP - 1; exp_ack = 0; exp_nak = 0; exp_to = 0; chk_aging = 1'b0;
        repeat (3) tick();
        check_reset_state();
        rst = 1'b0;

        // Aging request timing and acknowledge
        while (cyc < 99) tick();
        check("aging_before_wrap", 64'(aging_req), 64'(0));
        tick();
        check("aging_at_wrap", 64'(aging_req), 64'(1));
        while (cyc < 149) tick();
        aging_ack = 1'b1;
        tick();
        aging_ack = 1'b0;
        check("aging_cleared", 64'(aging_req), 64'(0));
        check("no_overrun", 64'(aging_overrun), 64'(0));

        // Round robin from reset pointer, with port 0 re-requesting
        raise(0, 1'b0, 48'hA0_0000_0000_00, 16'h0001, 10'h010);
        raise(1, 1'b1, 48'hA1_0000_0000_01, 16'h0002, 10'h011);
        raise(3, 1'b0, 48'hA3_0000_0000_03, 16'h0008, 10'h013);
        do_txn(0, 1, 16'h1111, 1'b0);
        raise(0, 1'b0, 48'hA0_0000_0000_10, 16'h0010, 10'h020);
        do_txn(0, 0, 16'h2222, 1'b0);
        do_txn(1, 2, 16'h3333, 1'b0);
        do_txn(0, 0, 16'h4444, 1'b0);
        check("rr_order_0", 64'(order[0]), 64'(0));
        check("rr_order_1", 64'(order[1]), 64'(1));
        check("rr_order_2", 64'(order[2]), 64'(3));
        check("rr_order_3", 64'(order[3]), 64'(0));

        // Port 2 lookup: one-cycle grant latency, result returned with ack
        raise(2, 1'b0, 48'h0011_2233_4455, 16'h0000, 10'h05A);
        tick();
        check("req_to_se_req", 64'(se_req), 64'(1));
        do_txn(0, 0, 16'h0008, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < int'(NP); p++)
                if (!pending[PW'(p)] && $urandom_range(0, 1) == 1)
                    raise(p, 1'($urandom_range(0, 1)), {8'(p), $urandom, 8'($urandom)},
                          16'($urandom), 10'($urandom));
            if (pending == '0)
                raise(it % int'(NP), 1'b0, {8'(it % int'(NP)), $urandom, 8'($urandom)},
                      16'($urandom), 10'($urandom));
            do_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 16'($urandom),
                   1'($urandom_range(0, 1)));
        end
        while (pending != '0) do_txn(0, 0, 16'($urandom), 1'b0);

        // Watchdog expiry; a late ack must be ignored
        raise(1, 1'b0, 48'hBB_0000_0000_01, 16'h0004, 10'h3FF);
        n = 0;
        while (!se_req && n < 10) begin tick(); n++; end
        check("to_se_req", 64'(se_req), 64'(1));
        n = 0;
        while (port_nak == '0 && n < int'(TO) + 20) begin tick(); n++; end
        check("timeout_latency", 64'(n >= int'(TO) && n <= int'(TO) + 1), 64'(1));
        check("timeout_nak", 64'(port_nak), 64'(4'b0010));
        check("timeout_err", 64'(timeout_err), 64'(1));
        check("timeout_se_req", 64'(se_req), 64'(0));
        port_req[1] = 1'b0;
        pending[1] = 1'b0;
        last = 1;
        exp_nak++;
        exp_to++;
        se_ack = 1'b1;
        tick();
        check("late_ack_0", 64'({port_ack, port_nak}), 64'(0));
        tick();
        se_ack = 1'b0;
        check("late_ack_1", 64'({port_ack, port_nak}), 64'(0));
        tick();
        check("late_ack_2", 64'({port_ack, port_nak, se_req}), 64'(0));
        check("timeout_sticky", 64'(timeout_err), 64'(1));

`ifdef MAC_ARB_STATS_EN
        check("stat_ack", 64'(stat_ack_cnt), 64'(exp_ack));
        check("stat_nak", 64'(stat_nak_cnt), 64'(exp_nak));
        check("stat_to", 64'(stat_to_cnt), 64'(exp_to));
`else
        check("stat_off", 64'({stat_ack_cnt, stat_nak_cnt}) | 64'(stat_to_cnt), 64'(0));
`endif

        // Reset in the middle of a transaction
        raise(0, 1'b0, 48'hCC_0000_0000_00, 16'h0001, 10'h001);
        n = 0;
        while (!se_req && n < 10) begin tick(); n++; end
        check("pre_rst_se_req", 64'(se_req), 64'(1));
        rst = 1'b1;
        tick();
        port_req = '0;
        pending = '0;
        last = NP - 1;
        tick();
        check_reset_state();
        rst = 1'b0;

        // Learn during an active sweep, then overrun on the next wrap
        while (cyc < 110) tick();
        check("sweep_active", 64'(aging_req), 64'(1));
        raise(1, 1'b1, 48'hDD_0000_0000_01, 16'h0F0F, 10'h155);
        chk_aging = 1'b1;
        do_txn(0, 6, 16'hBEEF, 1'b0);
        chk_aging = 1'b0;
        check("sweep_after_learn", 64'(aging_req), 64'(1));
        while (cyc < 199) tick();
        check("overrun_before", 64'(aging_overrun), 64'(0));
        tick();
        check("overrun_set", 64'({aging_overrun, aging_req}), 64'(2'b11));
        aging_ack = 1'b1;
        tick();
        aging_ack = 1'b0;
        check("aging_ack_clear", 64'({aging_overrun, aging_req}), 64'(2'b10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_lookup_arbiter.md
Name: mac_lookup_arbiter

Overview:
- Controller in front of the 2-bucket MAC hash table. Shares the table's single search/learn port among NUM_PORTS ingress requesters using round-robin arbitration.
- Generates the periodic aging request for the table and supervises every transaction with a watchdog.
- Returns per-port ack/nak/result, plus status and (optionally) statistics.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16)
- AGING_PERIOD, 32'd1000000, clk cycles between aging sweep starts
- TIMEOUT, 16'd2047, max cycles from se_req assertion to ack/nak; must exceed the table clear time of 1024+16 cycles

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- port_req  in  NUM_PORTS  per-port request; held until that port's ack or nak
- port_source  in  NUM_PORTS  1 = learn (source MAC), 0 = lookup (destination MAC)
- port_mac  in  48*NUM_PORTS  MAC; port i at [48i+47:48i]
- port_portmap  in  16*NUM_PORTS  learn portmap
- port_hash  in  10*NUM_PORTS  bucket index
- port_ack  out  NUM_PORTS  one-cycle success pulse
- port_nak  out  NUM_PORTS  one-cycle fail/miss/timeout pulse
- port_result  out  16  lookup portmap; valid with port_ack
- se_source, se_mac[47:0], se_portmap[15:0], se_hash[9:0], se_req  out  to table
- se_ack, se_nak  in  1  from table
- se_result  in  16  from table
- aging_req  out  1  to table, level
- aging_ack  in  1  from table, end of sweep
- timeout_err  out  1  sticky; set on watchdog expiry
- aging_overrun  out  1  sticky; set when an aging tick arrives while a sweep is still pending
- stat_ack_cnt, stat_nak_cnt, stat_to_cnt  out  32 each  (optional feature)

Behaviour:
- Reset values: all outputs 0. FSM = IDLE. RR pointer = NUM_PORTS-1, so port 0 wins first. Aging counter = 0.
- FSM IDLE:
  - If any port_req bit is set, grant the first requester after the RR pointer (wrapping).
  - Latch that port's source/mac/portmap/hash into the se_* registers, assert se_req, clear the watchdog, go to BUSY.
  - Grant decision and se_req assertion happen on the same edge; no bubble.
- FSM BUSY:
  - se_* are held stable and se_req stays high.
  - se_ack sampled: pulse port_ack[g]; drive port_result = se_result if latched source = 0, else 0.
  - se_nak sampled: pulse port_nak[g].
  - On either, deassert se_req, set RR pointer = g, go to RESP.
  - se_ack and se_nak together: treat as nak.
- FSM RESP: one idle cycle so the table's state-0 does not resample se_req; then go to IDLE.
- Watchdog:
  - Counts while in BUSY.
  - At count == TIMEOUT with no ack/nak: pulse port_nak[g], set timeout_err, deassert se_req, go to RESP.
  - A late ack/nak from the table while in RESP/IDLE with se_req low is ignored.
- Latency: port_req high in IDLE -> se_req next edge. Table ack -> port_ack the following cycle.
- A requester deasserting port_req mid-transaction does not abort it; the response pulse is still issued.
- Aging:
  - Free-running counter 0..AGING_PERIOD-1. On wrap, set aging_req.
  - aging_req clears the cycle after aging_ack is sampled.
  - A wrap while aging_req is still high sets aging_overrun; no second request is queued.
  - aging_req is independent of the lookup FSM; the table prioritises se_req, so lookups interleave with the sweep.
- rst mid-transaction returns everything to reset values. Requesters must re-issue their requests.

Optional Feature:
- MAC_ARB_STATS_EN defined: three 32-bit saturating counters (port_ack pulses, port_nak pulses including timeouts, timeouts only), cleared by rst.
- Undefined: stat_* outputs tied to 0 and no counter logic is built.

Test Plan:
- Port 2 lookup, mac 48'h0011_2233_4455, hash 10'h05A; table acks with result 16'h0008 -> se_req 1 cycle after req, port_ack[2] and port_result = 16'h0008 one cycle after se_ack, se_req low.
- Ports 0, 1, 3 request simultaneously and are held -> grants in order 0, 1, 3. Port 0 re-requests -> after 3, grant order continues 0.
- Table never responds -> after 2047 cycles port_nak[g] pulses, timeout_err = 1; a later se_ack produces no port pulse.
- AGING_PERIOD = 100 -> aging_req rises at cycle 100; aging_ack at 150 -> aging_req low at 151. With no aging_ack by cycle 200 -> aging_overrun = 1.
- Learn from port 1 during an active sweep -> se fields held stable until se_ack, then port_ack[1]; aging_req stays high throughout.
- With MAC_ARB_STATS_EN: 5 acks, 2 naks, 1 timeout -> stat_ack = 5, stat_nak = 3, stat_to = 1. Without the macro, all stat outputs stay 0.
